// File: rtl/pong_pkg.sv
// pong_pkg: shared constants and FSM encoding for the Pong ball and paddle blocks
package pong_pkg;
    localparam int CW            = 11;
    localparam int DEF_W_RES     = 640;
    localparam int DEF_H_RES     = 480;
    localparam int DEF_X_SIZE    = 154;
    localparam int DEF_Y_SIZE    = 16;
    localparam int DEF_H_BARRA   = 10;
    localparam int DEF_BALL_SIZE = 8;
    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, MISS = 2'd2} state_e;
endpackage

// File: rtl/pong_ball_if.sv
// pong_ball_if: ball engine bus
// master drives start, paddle position and scan coordinates; slave returns ball position, ball_on, miss count and FSM state
interface pong_ball_if;
    import pong_pkg::*;
    logic          start;
    logic [CW-1:0] x_bar_pos;
    logic [CW-1:0] y_bar_pos;
    logic [CW-1:0] x_coord;
    logic [CW-1:0] y_coord;
    logic [CW-1:0] ball_x;
    logic [CW-1:0] ball_y;
    logic          ball_on;
    logic [7:0]    miss_count;
    logic [1:0]    state_o;
    modport master (
        output start, x_bar_pos, y_bar_pos, x_coord, y_coord,
        input  ball_x, ball_y, ball_on, miss_count, state_o
    );
    modport slave (
        input  start, x_bar_pos, y_bar_pos, x_coord, y_coord,
        output ball_x, ball_y, ball_on, miss_count, state_o
    );
endinterface

// File: rtl/tick_divider.sv
// tick_divider: one-cycle tick every DIVISOR clocks, shared by ball and paddle logic
// Ports: CLOCK_50 clock, reset async active-low, tick pulse out
module tick_divider #(
    parameter int DIVISOR = 200000
) (
    input  logic CLOCK_50,
    input  logic reset,
    output logic tick
);
    localparam int NW = DIVISOR > 1 ? $clog2(DIVISOR) : 1;
    logic [NW-1:0] cnt_q, cnt_d;
    assign tick  = cnt_q == NW'(DIVISOR - 1);
    assign cnt_d = tick ? '0 : cnt_q + 1'b1;
    always_ff @(posedge CLOCK_50 or negedge reset)
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
endmodule

// File: rtl/pong_ball.sv
// pong_ball: ball engine -- moves the ball on a divided tick, bounces off walls and paddle, counts misses
// Ports: CLOCK_50 clock; reset async active-low; bus (pong_ball_if.slave):
//   in  start (active-low serve), x_bar_pos/y_bar_pos paddle, x_coord/y_coord scan
//   out ball_x/ball_y, ball_on, miss_count (saturating), state_o (IDLE=0 PLAY=1 MISS=2)
// Build option: SPEEDUP_EN makes every paddle hit add 1 to both steps, capped at MAX_STEP
module pong_ball
    import pong_pkg::*;
#(
    parameter int W_RES       = DEF_W_RES,
    parameter int H_RES       = DEF_H_RES,
    parameter int X_SIZE      = DEF_X_SIZE,
    parameter int Y_SIZE      = DEF_Y_SIZE,
    parameter int H_BARRA     = DEF_H_BARRA,
    parameter int BALL_SIZE   = DEF_BALL_SIZE,
    parameter int STEP_X      = 2,
    parameter int STEP_Y      = 2,
    parameter int MAX_STEP    = 6,
    parameter int DIVISOR     = 200000,
    parameter int SERVE_DELAY = 50
) (
    input logic        CLOCK_50,
    input logic        reset,
    pong_ball_if.slave bus
);
    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_PLAY = PLAY;
    localparam logic [1:0] S_MISS = MISS;
    localparam int DW = $clog2(SERVE_DELAY + 1);
    localparam logic [CW-1:0] BS    = CW'(BALL_SIZE);
    localparam logic [CW-1:0] WR    = CW'(W_RES);
    localparam logic [CW-1:0] HR    = CW'(H_RES);
    localparam logic [CW-1:0] XS    = CW'(X_SIZE);
    localparam logic [CW-1:0] X0    = CW'(W_RES / 2 - BALL_SIZE / 2);
    localparam logic [CW-1:0] Y0    = CW'(H_RES - H_BARRA - Y_SIZE - BALL_SIZE);
    localparam logic [CW-1:0] X_OFS = CW'(X_SIZE / 2 - BALL_SIZE / 2);
    // base steps never exceed the ceiling, so a speed-up can only make the ball faster
    localparam logic [CW-1:0] BASE_X = CW'(STEP_X < MAX_STEP ? STEP_X : MAX_STEP);
    localparam logic [CW-1:0] BASE_Y = CW'(STEP_Y < MAX_STEP ? STEP_Y : MAX_STEP);
    localparam logic [CW-1:0] CAP    = CW'(MAX_STEP);
    logic          tick;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] x_q, x_d, y_q, y_d;
    logic          dir_x_q, dir_x_d;  // 1 = right
    logic          dir_y_q, dir_y_d;  // 1 = up
    logic [7:0]    miss_q, miss_d;
    logic [DW-1:0] dly_q, dly_d;
    logic [CW-1:0] step_x, step_y;
    logic [CW-1:0] y_bot;
    logic          paddle_hit;
`ifdef SPEEDUP_EN
    logic [CW-1:0] step_x_q, step_x_d, step_y_q, step_y_d;
    assign step_x = step_x_q;
    assign step_y = step_y_q;
`else
    assign step_x = BASE_X;
    assign step_y = BASE_Y;
`endif
    tick_divider #(.DIVISOR(DIVISOR)) u_tick (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .tick     (tick)
    );
    assign y_bot = y_q + BS;
    // ball bottom crosses the paddle top this step while overlapping it horizontally (1-based edges)
    assign paddle_hit = y_bot <= bus.y_bar_pos && y_bot + step_y > bus.y_bar_pos &&
                        x_q + BS > bus.x_bar_pos && x_q <= bus.x_bar_pos + XS;
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        dir_x_d = dir_x_q;
        dir_y_d = dir_y_q;
        miss_d  = miss_q;
        dly_d   = dly_q;
`ifdef SPEEDUP_EN
        step_x_d = step_x_q;
        step_y_d = step_y_q;
`endif
        if (state_q == S_IDLE) begin
            x_d = bus.x_bar_pos + X_OFS;
            y_d = bus.y_bar_pos - BS;
            if (tick && !bus.start) begin
                state_d = S_PLAY;
                dir_x_d = 1'b1;
                dir_y_d = 1'b1;
            end
        end else if (tick && state_q == S_PLAY) begin
            if (!dir_x_q) begin
                x_d     = x_q < step_x ? '0 : x_q - step_x;
                dir_x_d = x_q < step_x;
            end else begin
                x_d     = x_q + BS + step_x > WR ? WR - BS : x_q + step_x;
                dir_x_d = !(x_q + BS + step_x > WR);
            end
            if (dir_y_q) begin
                y_d     = y_q < step_y ? '0 : y_q - step_y;
                dir_y_d = !(y_q < step_y);
            end else if (paddle_hit) begin
                y_d     = bus.y_bar_pos - BS;
                dir_y_d = 1'b1;
`ifdef SPEEDUP_EN
                step_x_d = step_x_q < CAP ? step_x_q + 1'b1 : step_x_q;
                step_y_d = step_y_q < CAP ? step_y_q + 1'b1 : step_y_q;
`endif
            end else if (y_bot + step_y >= HR) begin
                // the ball freezes where it left the field
                y_d     = HR - BS;
                x_d     = x_q;
                dir_x_d = dir_x_q;
                miss_d  = miss_q == 8'hFF ? miss_q : miss_q + 1'b1;
                state_d = S_MISS;
`ifdef SPEEDUP_EN
                step_x_d = BASE_X;
                step_y_d = BASE_Y;
`endif
            end else begin
                y_d = y_q + step_y;
            end
        end else if (tick && state_q == S_MISS) begin
            dly_d   = dly_q == DW'(SERVE_DELAY - 1) ? '0 : dly_q + 1'b1;
            state_d = dly_q == DW'(SERVE_DELAY - 1) ? S_IDLE : S_MISS;
        end
    end
    always_ff @(posedge CLOCK_50 or negedge reset)
        if (!reset) begin
            state_q <= S_IDLE;
            x_q     <= X0;
            y_q     <= Y0;
            dir_x_q <= 1'b1;
            dir_y_q <= 1'b1;
            miss_q  <= '0;
            dly_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dir_x_q <= dir_x_d;
            dir_y_q <= dir_y_d;
            miss_q  <= miss_d;
            dly_q   <= dly_d;
        end
`ifdef SPEEDUP_EN
    always_ff @(posedge CLOCK_50 or negedge reset)
        if (!reset) begin
            step_x_q <= BASE_X;
            step_y_q <= BASE_Y;
        end else begin
            step_x_q <= step_x_d;
            step_y_q <= step_y_d;
        end
`endif
    assign bus.ball_x     = x_q;
    assign bus.ball_y     = y_q;
    assign bus.miss_count = miss_q;
    assign bus.state_o    = state_q;
    assign bus.ball_on    = bus.x_coord > x_q && bus.x_coord <= x_q + BS &&
                            bus.y_coord > y_q && bus.y_coord <= y_q + BS;
endmodule

// File: tb/tb_pong_ball.sv
// tb_pong_ball: directed table-driven bench for pong_ball with DIVISOR=4
module tb_pong_ball;
    import pong_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;
    always #5 clk = ~clk;
    pong_ball_if bus();
    pong_ball #(.DIVISOR(4)) dut (
        .CLOCK_50 (clk),
        .reset    (rst_n),
        .bus      (bus)
    );
    typedef struct {
        int xb, yb, xc, yc;
        int ex, ey, eon;
    } idle_vec_t;
    typedef struct {
        int t, xb, st;
        int ex, ey, es, em;
    } way_t;
    idle_vec_t iv[8];
    way_t wv[30];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    task automatic chk_ball(input string name, input int ex, input int ey, input int es, input int em);
        chk({name, ".x"}, 32'(bus.ball_x), ex);
        chk({name, ".y"}, 32'(bus.ball_y), ey);
        chk({name, ".state"}, 32'(bus.state_o), es);
        chk({name, ".miss"}, 32'(bus.miss_count), em);
    endtask
    // one movement tick = 4 clocks; callers stay aligned to tick boundaries
    task automatic ticks(input int n);
        repeat (4 * n) @(posedge clk);
        #1;
    endtask
    initial begin
        int cur;
        iv[0] = '{243, 454, 317, 447, 316, 446, 1};
        iv[1] = '{243, 454, 316, 447, 316, 446, 0};
        iv[2] = '{243, 454, 324, 454, 316, 446, 1};
        iv[3] = '{243, 454, 325, 450, 316, 446, 0};
        iv[4] = '{243, 454, 320, 446, 316, 446, 0};
        iv[5] = '{0,   8,   74,  1,   73,  0,   1};
        iv[6] = '{486, 454, 559, 446, 559, 446, 0};
        iv[7] = '{100, 200, 180, 199, 173, 192, 1};
        // waypoints after serve at t=0 with bar x=486: right wall, top wall, left wall,
        // paddle hit (bar x=150), right-wall/top corner run, then miss with bar x=0 and serve delay
        wv[0]  = '{36,  486, 1, 631, 374, 1, 0};
        wv[1]  = '{37,  486, 1, 632, 372, 1, 0};
        wv[2]  = '{38,  486, 1, 630, 370, 1, 0};
        wv[3]  = '{222, 486, 1, 262, 2,   1, 0};
        wv[4]  = '{223, 486, 1, 260, 0,   1, 0};
        wv[5]  = '{224, 486, 1, 258, 0,   1, 0};
        wv[6]  = '{225, 486, 1, 256, 2,   1, 0};
        wv[7]  = '{352, 486, 1, 2,   256, 1, 0};
        wv[8]  = '{353, 486, 1, 0,   258, 1, 0};
        wv[9]  = '{354, 486, 1, 0,   260, 1, 0};
        wv[10] = '{355, 486, 1, 2,   262, 1, 0};
        wv[11] = '{446, 150, 1, 184, 444, 1, 0};
        wv[12] = '{447, 150, 1, 186, 446, 1, 0};
        wv[13] = '{448, 150, 1, 188, 446, 1, 0};
        wv[14] = '{449, 150, 1, 190, 444, 1, 0};
        wv[15] = '{669, 0,   1, 630, 4,   1, 0};
        wv[16] = '{670, 0,   1, 632, 2,   1, 0};
        wv[17] = '{671, 0,   1, 632, 0,   1, 0};
        wv[18] = '{672, 0,   1, 630, 0,   1, 0};
        wv[19] = '{673, 0,   1, 628, 2,   1, 0};
        wv[20] = '{895, 0,   1, 184, 446, 1, 0};
        wv[21] = '{896, 0,   1, 182, 448, 1, 0};
        wv[22] = '{907, 0,   1, 160, 470, 1, 0};
        wv[23] = '{908, 0,   1, 160, 472, 2, 1};
        wv[24] = '{957, 0,   0, 160, 472, 2, 1};
        wv[25] = '{958, 0,   0, 160, 472, 0, 1};
        bus.start = 1'b1;
        bus.x_bar_pos = 11'd0;
        bus.y_bar_pos = 11'd8;
        bus.x_coord = 11'd317;
        bus.y_coord = 11'd447;
        repeat (3) @(posedge clk);
        #1;
        chk_ball("reset", 316, 446, 0, 0);
        chk("reset.on_in", 32'(bus.ball_on), 1);
        bus.x_coord = 11'd316;
        #1;
        chk("reset.on_edge", 32'(bus.ball_on), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.x_bar_pos = 11'(iv[i].xb);
            bus.y_bar_pos = 11'(iv[i].yb);
            bus.x_coord = 11'(iv[i].xc);
            bus.y_coord = 11'(iv[i].yc);
            @(posedge clk);
            #1;
            chk($sformatf("idle%0d.x", i), 32'(bus.ball_x), iv[i].ex);
            chk($sformatf("idle%0d.y", i), 32'(bus.ball_y), iv[i].ey);
            chk($sformatf("idle%0d.on", i), 32'(bus.ball_on), iv[i].eon);
            chk($sformatf("idle%0d.state", i), 32'(bus.state_o), 0);
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.x_bar_pos = 11'd486;
        bus.y_bar_pos = 11'd454;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        chk("serve.offtick", 32'(bus.state_o), 0);
        repeat (3) @(posedge clk);
        #1;
        bus.start = 1'b1;
        chk_ball("serve", 559, 446, 1, 0);
        cur = 0;
        for (int i = 0; i < 26; i++) begin
            bus.x_bar_pos = 11'(wv[i].xb);
            bus.start = wv[i].st[0];
            ticks(wv[i].t - cur);
            cur = wv[i].t;
            chk_ball($sformatf("t%0d", cur), wv[i].ex, wv[i].ey, wv[i].es, wv[i].em);
        end
        @(posedge clk);
        #1;
        chk_ball("snap", 73, 446, 0, 1);
        repeat (3) @(posedge clk);
        #1;
        chk_ball("reserve", 73, 446, 1, 1);
        bus.start = 1'b1;
        ticks(3);
        chk_ball("replay", 79, 440, 1, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_ball("async_rst", 316, 446, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
